// File: rtl/mul_issue_controller.sv
// Issue/stall sequencer for the multi-cycle EX-stage multiplier: starts the multiplier on a MUL,
// stalls the front of the pipe until the product is ready, then steers it onto the EX/MEM path.
module mul_issue_controller #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              ex_valid,
  input  logic [1:0]        ex_alu_op,
  input  logic              flush,
  output logic              mul_start,
  output logic              mul_ce,
  output logic              stall,
  output logic              mul_sel,
  output logic              busy,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   perf_q, perf_d;
  logic                go;

  // Qualifying with arst_n keeps every output low while reset is held, even with a MUL in EX.
  assign go = arst_n & enable & ex_valid & (ex_alu_op == 2'b11) & ~flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    mul_ce    = 1'b0;
    stall     = 1'b0;
    mul_sel   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (go) begin
          mul_start = 1'b1;
          mul_ce    = 1'b1;
          stall     = 1'b1;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall  = 1'b1;
          mul_ce = enable;
          if (enable) begin
            if (cnt_q == '0) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          mul_sel = 1'b1;
          // The MUL retires from EX this cycle, so it must not be re-issued.
          if (enable) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (stall && enable && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_mul_issue_controller.sv
// Directed bench for mul_issue_controller: LATENCY=2 main instance plus a LATENCY=1,
// 2-bit-counter instance used for the short-latency and counter-saturation cases.
module tb_mul_issue_controller;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        ex_valid;
  logic [1:0]  ex_alu_op;
  logic        flush;

  logic        mul_start0, mul_ce0, stall0, mul_sel0, busy0;
  logic [31:0] perf0;
  logic        mul_start1, mul_ce1, stall1, mul_sel1, busy1;
  logic [1:0]  perf1;

  int vectors     = 0;
  int miscompares = 0;

  // Output vector order used by every expectation: {mul_start, mul_ce, stall, mul_sel, busy}
  localparam logic [4:0] O_ZERO  = 5'b00000;
  localparam logic [4:0] O_GO    = 5'b11100;
  localparam logic [4:0] O_BUSY  = 5'b01101;
  localparam logic [4:0] O_BUSYH = 5'b00101;
  localparam logic [4:0] O_DONE  = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b00001;

  always #5 clk = ~clk;

  mul_issue_controller #(.LATENCY(2), .CNT_W(4), .PERF_W(32)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .flush(flush),
    .mul_start(mul_start0), .mul_ce(mul_ce0), .stall(stall0), .mul_sel(mul_sel0),
    .busy(busy0), .perf_stall_cnt(perf0)
  );

  mul_issue_controller #(.LATENCY(1), .CNT_W(4), .PERF_W(2)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .enable(enable), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .flush(flush),
    .mul_start(mul_start1), .mul_ce(mul_ce1), .stall(stall1), .mul_sel(mul_sel1),
    .busy(busy1), .perf_stall_cnt(perf1)
  );

  function automatic logic [4:0] obs0();
    return {mul_start0, mul_ce0, stall0, mul_sel0, busy0};
  endfunction

  function automatic logic [4:0] obs1();
    return {mul_start1, mul_ce1, stall1, mul_sel1, busy1};
  endfunction

  task automatic check_out(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %b expected %b ({start,ce,stall,sel,busy})", tag, obs, exp);
      $error("output check %s", tag);
    end
  endtask

  task automatic check_perf(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed perf %0d expected %0d", tag, obs, exp);
      $error("perf check %s", tag);
    end
  endtask

  task automatic drive(input logic en, input logic v, input logic [1:0] op, input logic fl);
    enable    = en;
    ex_valid  = v;
    ex_alu_op = op;
    flush     = fl;
  endtask

  // One pipeline cycle on the LATENCY=2 instance: drive, check at negedge, advance past posedge.
  task automatic step0(input string tag, input logic en, input logic v, input logic [1:0] op,
                       input logic fl, input logic [4:0] exp);
    drive(en, v, op, fl);
    @(negedge clk);
    check_out(tag, obs0(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input logic en, input logic v, input logic [1:0] op,
                       input logic fl, input logic [4:0] exp);
    drive(en, v, op, fl);
    @(negedge clk);
    check_out(tag, obs1(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    arst_n = 1'b0;
    #2;
    check_out("reset_outputs", obs0(), O_ZERO);
    check_perf("reset_perf", perf0, 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Single MUL
    step0("t1_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t1_c1", 1'b1, 1'b1, 2'b11, 1'b0, O_BUSY);
    step0("t1_c2", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t1_c3", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);
    check_perf("t1_perf", perf0, 32'd2);

    // Back-to-back MULs, no gap cycle
    do_reset();
    step0("t2_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t2_c1", 1'b1, 1'b1, 2'b11, 1'b0, O_BUSY);
    step0("t2_c2", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t2_c3", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t2_c4", 1'b1, 1'b1, 2'b11, 1'b0, O_BUSY);
    step0("t2_c5", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t2_c6", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);
    check_perf("t2_perf", perf0, 32'd4);

    // Flush in BUSY, then flush in IDLE suppressing a MUL
    do_reset();
    step0("t3_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t3_c1_flush", 1'b1, 1'b1, 2'b11, 1'b1, O_FLUSH);
    step0("t3_c2", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);
    step0("t3_idle_flush", 1'b1, 1'b1, 2'b11, 1'b1, O_ZERO);
    step0("t3_after", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);
    check_perf("t3_perf", perf0, 32'd1);

    // Flush in DONE while disabled: flush wins over enable
    do_reset();
    step0("t3b_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t3b_c1", 1'b1, 1'b1, 2'b11, 1'b0, O_BUSY);
    step0("t3b_c2_flush", 1'b0, 1'b1, 2'b11, 1'b1, O_FLUSH);
    step0("t3b_c3", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);

    // Pipeline disabled for two cycles mid-BUSY; ex inputs toggled while BUSY are ignored
    do_reset();
    step0("t4_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t4_c1", 1'b0, 1'b1, 2'b11, 1'b0, O_BUSYH);
    step0("t4_c2", 1'b0, 1'b0, 2'b01, 1'b0, O_BUSYH);
    step0("t4_c3", 1'b1, 1'b0, 2'b00, 1'b0, O_BUSY);
    step0("t4_c4", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t4_c5", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);
    check_perf("t4_perf", perf0, 32'd2);

    // DONE held while disabled
    do_reset();
    step0("t4b_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step0("t4b_c1", 1'b1, 1'b1, 2'b11, 1'b0, O_BUSY);
    step0("t4b_c2", 1'b0, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t4b_c3", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step0("t4b_c4", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);

    // Asynchronous reset mid-BUSY with a MUL still presented
    do_reset();
    step0("t5_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    check_out("t5_c1_busy", obs0(), O_BUSY);
    check_perf("t5_perf_pre", perf0, 32'd1);
    #1;
    arst_n = 1'b0;
    #1;
    check_out("t5_in_reset", obs0(), O_ZERO);
    check_perf("t5_perf_reset", perf0, 32'd0);
    @(posedge clk);
    #1;
    check_out("t5_held_reset", obs0(), O_ZERO);
    arst_n = 1'b1;
    step0("t5_release", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);

    // LATENCY=1 instance, then counter saturation on its 2-bit counter
    do_reset();
    step1("t6_c0", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step1("t6_c1", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    check_perf("t6_perf", {30'd0, perf1}, 32'd1);
    step1("t6_c2", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step1("t6_c3", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    step1("t6_c4", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step1("t6_c5", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    check_perf("t6_perf3", {30'd0, perf1}, 32'd3);
    step1("t6_c6", 1'b1, 1'b1, 2'b11, 1'b0, O_GO);
    step1("t6_c7", 1'b1, 1'b1, 2'b11, 1'b0, O_DONE);
    check_perf("t6_perf_sat", {30'd0, perf1}, 32'd3);
    step1("t6_c8", 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO);

    // Non-MUL ALUOps never start anything
    do_reset();
    step0("t6_op10", 1'b1, 1'b1, 2'b10, 1'b0, O_ZERO);
    step0("t6_op10b", 1'b1, 1'b1, 2'b10, 1'b0, O_ZERO);
    step0("t6_op00", 1'b1, 1'b1, 2'b00, 1'b0, O_ZERO);
    step0("t6_op01", 1'b1, 1'b1, 2'b01, 1'b0, O_ZERO);
    step0("t6_mul_bubble", 1'b1, 1'b0, 2'b11, 1'b0, O_ZERO);
    step0("t6_mul_frozen", 1'b0, 1'b1, 2'b11, 1'b0, O_ZERO);
    check_perf("t6_op_perf", perf0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
